// File: rtl/wallace_mul_pipe.sv
// Three-stage pipelined Wallace-tree multiplier (partial products, 3:2 reduction tree, final adder).
// Signed operands use modified Baugh-Wooley terms so one unsigned tree serves both modes.
module wallace_mul_pipe #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p
);

   localparam int PW     = 2 * WIDTH;
   localparam int HMAX   = WIDTH + 2;
   localparam int GMAX   = HMAX / 3 + 1;
   localparam int LEVELS = WIDTH;

   logic              stall;
   logic              advance;
   logic [WIDTH-1:0]  pp_d [WIDTH];
   logic [WIDTH-1:0]  pp_q [WIDTH];
   logic              mode_q;
   logic              v1_q;
   logic              v2_q;
   logic [PW-1:0]     sum_d;
   logic [PW-1:0]     carry_d;
   logic [PW-1:0]     sum_q;
   logic [PW-1:0]     carry_q;

   logic [HMAX-1:0]   col   [PW];
   int                cnt   [PW];
   logic [HMAX-1:0]   s_vec [PW];
   logic [HMAX-1:0]   c_vec [PW];
   int                s_n   [PW];
   int                c_n   [PW];
   logic [HMAX-1:0]   tmp;
   logic              busy;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign advance  = !stall;

   // Row i holds a*b[i]; in signed mode the MSB terms (except the corner) are inverted.
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            pp_d[i][j] = (a[j] & b[i]) ^ (signed_mode & ((i == WIDTH-1) ^ (j == WIDTH-1)));
         end
      end
   end

   // Columns are bit bags; each level applies greedy full/half adders until every column holds <= 2 bits.
   always_comb begin
      tmp  = '0;
      busy = 1'b0;
      for (int c = 0; c < PW; c++) begin
         col[c]   = '0;
         cnt[c]   = 0;
         s_vec[c] = '0;
         c_vec[c] = '0;
         s_n[c]   = 0;
         c_n[c]   = 0;
      end

      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            col[i+j] = col[i+j] | (HMAX'(pp_q[i][j]) << cnt[i+j]);
            cnt[i+j] = cnt[i+j] + 1;
         end
      end
      col[WIDTH]  = col[WIDTH] | (HMAX'(mode_q) << cnt[WIDTH]);
      cnt[WIDTH]  = cnt[WIDTH] + 1;
      col[PW-1]   = col[PW-1] | (HMAX'(mode_q) << cnt[PW-1]);
      cnt[PW-1]   = cnt[PW-1] + 1;

      for (int lvl = 0; lvl < LEVELS; lvl++) begin
         busy = 1'b0;
         for (int c = 0; c < PW; c++) begin
            if (cnt[c] > 2) busy = 1'b1;
         end
         if (busy) begin
            for (int c = 0; c < PW; c++) begin
               s_vec[c] = '0;
               c_vec[c] = '0;
               s_n[c]   = 0;
               c_n[c]   = 0;
               for (int g = 0; g < GMAX; g++) begin
                  tmp = col[c] >> (3 * g);
                  if (3 * g + 3 <= cnt[c]) begin
                     s_vec[c] = s_vec[c] | (HMAX'(tmp[0] ^ tmp[1] ^ tmp[2]) << s_n[c]);
                     s_n[c]   = s_n[c] + 1;
                     c_vec[c] = c_vec[c] |
                                (HMAX'((tmp[0] & tmp[1]) | (tmp[0] & tmp[2]) | (tmp[1] & tmp[2])) << c_n[c]);
                     c_n[c]   = c_n[c] + 1;
                  end else if (3 * g + 2 == cnt[c]) begin
                     s_vec[c] = s_vec[c] | (HMAX'(tmp[0] ^ tmp[1]) << s_n[c]);
                     s_n[c]   = s_n[c] + 1;
                     c_vec[c] = c_vec[c] | (HMAX'(tmp[0] & tmp[1]) << c_n[c]);
                     c_n[c]   = c_n[c] + 1;
                  end else if (3 * g + 1 == cnt[c]) begin
                     s_vec[c] = s_vec[c] | (HMAX'(tmp[0]) << s_n[c]);
                     s_n[c]   = s_n[c] + 1;
                  end
               end
            end
            // Carries move one column left; the carry out of the top column is dropped.
            col[0] = s_vec[0];
            cnt[0] = s_n[0];
            for (int c = 1; c < PW; c++) begin
               col[c] = s_vec[c] | (c_vec[c-1] << s_n[c]);
               cnt[c] = s_n[c] + c_n[c-1];
            end
         end
      end

      for (int c = 0; c < PW; c++) begin
         sum_d[c]   = col[c][0];
         carry_d[c] = col[c][1];
      end
   end

   // Global stall: every stage holds together; data registers only load behind a valid bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            pp_q[i] <= '0;
         end
         mode_q    <= 1'b0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         sum_q     <= '0;
         carry_q   <= '0;
         out_valid <= 1'b0;
         p         <= '0;
      end else if (advance) begin
         v1_q      <= in_valid;
         v2_q      <= v1_q;
         out_valid <= v2_q;
         if (in_valid) begin
            pp_q   <= pp_d;
            mode_q <= signed_mode;
         end
         if (v1_q) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
         end
         if (v2_q) begin
            p <= sum_q + carry_q;
         end
      end
   end

endmodule
